// File: rtl/data_memory_responder.sv
// Byte-addressed data memory serving RV32I loads and stores over a valid/ready
// request/response handshake, with a fixed programmable access latency.
module data_memory_responder #(
    parameter int unsigned START_ADDRESS = 0,
    parameter int unsigned STOP_ADDRESS  = 1023,
    parameter int unsigned LATENCY       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH = (STOP_ADDRESS - START_ADDRESS + 1) / 4;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           cap_we;
    logic [31:0]    cap_addr;
    logic [2:0]     cap_funct3;
    logic [31:0]    cap_wdata;

    logic [31:0]    mem [DEPTH];

    logic [2:0]     size;
    logic [32:0]    end_addr;
    logic           illegal;
    logic           out_of_range;
    logic           misaligned;
    logic           err;
    logic [AW-1:0]  widx;
    logic [31:0]    rword;
    logic [15:0]    lane_half;
    logic [31:0]    load_data;
    logic [3:0]     wmask;
    logic [31:0]    wrep;
    logic           commit;

    // Request capture: inputs are only looked at on the accept edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid && req_ready) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_funct3 <= req_funct3;
            cap_wdata  <= req_wdata;
        end
    end

    // Decode and error checks on the captured request.
    always_comb begin
        size = 3'd1;
        case (cap_funct3[1:0])
            2'd0:    size = 3'd1;
            2'd1:    size = 3'd2;
            2'd2:    size = 3'd4;
            default: size = 3'd1;
        endcase
        illegal      = (cap_funct3[1:0] == 2'b11) ||
                       (cap_funct3[2] && (cap_we || cap_funct3[1]));
        end_addr     = {1'b0, cap_addr} + 33'(size) - 33'd1;
        out_of_range = (cap_addr < 32'(START_ADDRESS)) || (end_addr > 33'(STOP_ADDRESS));
        misaligned   = ((cap_funct3[1:0] == 2'd1) && cap_addr[0]) ||
                       ((cap_funct3[1:0] == 2'd2) && (cap_addr[1:0] != 2'b00));
        err          = illegal || out_of_range || misaligned;
        commit       = (state == ACCESS) && (cnt == '0);
    end

    // Little-endian lane selection and extension for loads.
    always_comb begin
        widx      = AW'((cap_addr - 32'(START_ADDRESS)) >> 2);
        rword     = mem[widx];
        lane_half = 16'(rword >> {cap_addr[1:0], 3'b000});
        case (cap_funct3)
            3'd0:    load_data = {{24{lane_half[7]}}, lane_half[7:0]};
            3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
            3'd2:    load_data = rword;
            3'd4:    load_data = {24'd0, lane_half[7:0]};
            3'd5:    load_data = {16'd0, lane_half};
            default: load_data = 32'd0;
        endcase
    end

    // Byte-enable and replicated write data for stores.
    always_comb begin
        wmask = 4'b0000;
        wrep  = cap_wdata;
        case (cap_funct3[1:0])
            2'd0: begin
                wmask = 4'b0001 << cap_addr[1:0];
                wrep  = {4{cap_wdata[7:0]}};
            end
            2'd1: begin
                wmask = 4'b0011 << cap_addr[1:0];
                wrep  = {2{cap_wdata[15:0]}};
            end
            2'd2: begin
                wmask = 4'b1111;
                wrep  = cap_wdata;
            end
            default: begin
                wmask = 4'b0000;
                wrep  = cap_wdata;
            end
        endcase
    end

    // Array is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && commit && cap_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[widx][8*i +: 8] <= wrep[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || cap_we) ? 32'd0 : load_data;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance at latency 1, one at
// latency 3, sharing clock, reset and request payload lines.
module tb_data_memory_responder;

    localparam int BUDGET = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    wire  [1:0]  req_ready;
    wire  [1:0]  resp_valid;
    wire  [1:0]  resp_err;
    wire  [31:0] rdata0;
    wire  [31:0] rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.START_ADDRESS(0), .STOP_ADDRESS(1023), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(rdata0), .resp_err(resp_err[0])
    );

    data_memory_responder #(.START_ADDRESS(0), .STOP_ADDRESS(1023), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(rdata1), .resp_err(resp_err[1])
    );

    function automatic logic [31:0] rdata_of(input int s);
        return (s == 0) ? rdata0 : rdata1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction with resp_ready high; scrambles the payload after accept.
    task automatic xact(input int s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready[s] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("accept_timeout", 32'(n), 32'(BUDGET - 1));
        req_we       = we;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid[s] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        req_we       = ~we;
        req_addr     = 32'hFFFF_FFFF;
        req_funct3   = 3'd7;
        req_wdata    = ~wd;
        lat = 0;
        while (resp_valid[s] !== 1'b1 && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rdata_of(s);
        er = resp_err[s];
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int s, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(s, 1'b0, f3, a, 32'h0, rd, er, lat);
        check({tag, "_rdata"}, rd, exp_d);
        check({tag, "_err"}, 32'(er), 32'(exp_e));
        check({tag, "_lat"}, 32'(lat), (s == 0) ? 32'd1 : 32'd3);
    endtask

    task automatic st(input int s, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_e, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(s, 1'b1, f3, a, wd, rd, er, lat);
        check({tag, "_rdata"}, rd, 32'h0);
        check({tag, "_err"}, 32'(er), 32'(exp_e));
        check({tag, "_lat"}, 32'(lat), (s == 0) ? 32'd1 : 32'd3);
    endtask

    task automatic check_idle(input int s, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[s]), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid[s]), 32'd0);
        check({tag, "_rdata"}, rdata_of(s), 32'd0);
        check({tag, "_err"}, 32'(resp_err[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'd0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_idle(0, "reset_l1");
        check_idle(1, "reset_l3");
        @(negedge clk);
        rst = 1'b1;

        // Word store/load round trip.
        st(0, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, "sw_10");
        ld(0, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, "lw_10");

        // Sign and zero extension.
        st(0, 3'd2, 32'h20, 32'h80FF_7F01, 1'b0, "sw_20");
        ld(0, 3'd0, 32'h23, 32'hFFFF_FF80, 1'b0, "lb_23");
        ld(0, 3'd4, 32'h23, 32'h0000_0080, 1'b0, "lbu_23");
        ld(0, 3'd1, 32'h22, 32'hFFFF_80FF, 1'b0, "lh_22");
        ld(0, 3'd5, 32'h20, 32'h0000_7F01, 1'b0, "lhu_20");
        ld(0, 3'd0, 32'h20, 32'h0000_0001, 1'b0, "lb_20");

        // Partial stores leave other lanes alone.
        st(0, 3'd2, 32'h40, 32'h1122_3344, 1'b0, "sw_40");
        st(0, 3'd0, 32'h41, 32'h5555_55AA, 1'b0, "sb_41");
        st(0, 3'd1, 32'h42, 32'h6666_BBCC, 1'b0, "sh_42");
        ld(0, 3'd2, 32'h40, 32'hBBCC_AA44, 1'b0, "lw_40");

        // Errors have no side effect.
        ld(0, 3'd2, 32'h42, 32'h0, 1'b1, "lw_mis_42");
        st(0, 3'd1, 32'h41, 32'h0000_FFFF, 1'b1, "sh_mis_41");
        st(0, 3'd5, 32'h40, 32'h0000_0000, 1'b1, "st_f3_5");
        ld(0, 3'd2, 32'h40, 32'hBBCC_AA44, 1'b0, "lw_40_kept");
        ld(0, 3'd2, 32'h400, 32'h0, 1'b1, "lw_oor_400");
        ld(0, 3'd3, 32'h0, 32'h0, 1'b1, "ld_f3_3");
        ld(0, 3'd6, 32'h0, 32'h0, 1'b1, "ld_f3_6");
        st(0, 3'd2, 32'h3FC, 32'hCAFE_F00D, 1'b0, "sw_3fc");
        ld(0, 3'd2, 32'h3FE, 32'h0, 1'b1, "lw_mis_3fe");
        ld(0, 3'd4, 32'h3FF, 32'h0000_00CA, 1'b0, "lbu_3ff");
        ld(0, 3'd5, 32'h3FF, 32'h0, 1'b1, "lhu_3ff");
        ld(0, 3'd2, 32'h3FC, 32'hCAFE_F00D, 1'b0, "lw_3fc");

        // Latency 3 with response backpressure and a request held while busy.
        st(1, 3'd2, 32'h10, 32'hA5A5_A5A5, 1'b0, "l3_sw_10");
        st(1, 3'd2, 32'h14, 32'h5A5A_0000, 1'b0, "l3_sw_14");
        @(negedge clk);
        resp_ready[1] = 1'b0;
        req_we        = 1'b0;
        req_funct3    = 3'd2;
        req_addr      = 32'h10;
        req_valid[1]  = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h14;
        n = 0;
        while (resp_valid[1] !== 1'b1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid[1]), 32'd1);
            check("bp_rdata", rdata1, 32'hA5A5_A5A5);
            check("bp_req_ready", 32'(req_ready[1]), 32'd0);
        end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drop_valid", 32'(resp_valid[1]), 32'd0);
        check("bp_idle_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        check("bp_next_accept", 32'(req_ready[1]), 32'd0);
        req_valid[1] = 1'b0;
        req_addr     = 32'hFFFF_FFFF;
        n = 0;
        while (resp_valid[1] !== 1'b1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_next_lat", 32'(n), 32'd3);
        check("bp_next_rdata", rdata1, 32'h5A5A_0000);
        @(posedge clk);
        #1;

        // Reset in the second ACCESS cycle of a store cancels the write.
        st(1, 3'd2, 32'h80, 32'h0000_0000, 1'b0, "l3_sw_80_clr");
        @(negedge clk);
        req_we       = 1'b1;
        req_funct3   = 3'd2;
        req_addr     = 32'h80;
        req_wdata    = 32'h1234_5678;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle(1, "mid_rst");
        @(negedge clk);
        rst = 1'b1;
        ld(1, 3'd2, 32'h80, 32'h0000_0000, 1'b0, "l3_lw_80");
        ld(0, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, "l1_lw_10_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
